// File: rtl/iter_mul.sv
// iter_mul: iterative shift-add multiplier for the EX stage.
// Produces the low WIDTH bits of src1_i * src2_i, one partial product per
// cycle, and holds the pipeline through stall_o while it works. The result,
// its zero flag and its destination tag are registered and announced with a
// one-cycle valid_o pulse.
module iter_mul #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [4:0]       rd_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic [4:0]       rd_o
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Working registers of the current operation.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [4:0]       tag;

    // Values after one shift-add iteration.
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mcand_step;
    logic [WIDTH-1:0] mplier_step;
    logic [CW-1:0]    cnt_step;
    logic             last_iter;

    // FSM decisions shared by the control and datapath processes.
    logic             accept;
    logic             finish;

    // One shift-add iteration and the test for whether it is the final one.
    always_comb begin
        acc_step    = mplier[0] ? (acc + mcand) : acc;
        mcand_step  = mcand << 1;
        mplier_step = mplier >> 1;
        cnt_step    = cnt + CW'(1);
        last_iter   = (cnt_step == CNT_LAST) ||
                      (EARLY_OUT && (mplier_step == '0));
    end

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves one unassigned and infers a latch.
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_i && !flush_i) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand load on an accepted start, one iteration per BUSY cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            tag    <= '0;
        end else if (accept) begin
            mcand  <= src1_i;
            mplier <= src2_i;
            acc    <= '0;
            cnt    <= '0;
            tag    <= rd_i;
        end else if (state == BUSY && !flush_i) begin
            mcand  <= mcand_step;
            mplier <= mplier_step;
            acc    <= acc_step;
            cnt    <= cnt_step;
        end
    end

    // Result registers, written only when an unflushed operation completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
            zero_o <= 1'b0;
            rd_o   <= '0;
        end else if (finish) begin
            data_o <= acc_step;
            zero_o <= (acc_step == '0);
            rd_o   <= tag;
        end
    end

    // Status outputs; stall drops in DONE so the pipeline takes the result.
    always_comb begin
        busy_o  = (state == BUSY);
        valid_o = (state == DONE);
        stall_o = ((state == BUSY) && !flush_i) || accept;
    end

endmodule

// File: tb/tb_iter_mul.sv
// tb_iter_mul: directed tests for iter_mul with hand-computed results.
// dut drives the early-out build; dut_full is the fixed-latency build.
module tb_iter_mul;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start2;
    logic        flush;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rd;

    logic        busy_o, stall_o, valid_o, zero_o;
    logic [31:0] data_o;
    logic [4:0]  rd_o;

    logic        busy2, stall2, valid2, zero2;
    logic [31:0] data2;
    logic [4:0]  rd2;

    int total = 0;
    int bad   = 0;

    localparam int BUDGET = 100;

    iter_mul #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .flush_i (flush),
        .src1_i  (src1),
        .src2_i  (src2),
        .rd_i    (rd),
        .busy_o  (busy_o),
        .stall_o (stall_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .zero_o  (zero_o),
        .rd_o    (rd_o)
    );

    iter_mul #(.WIDTH(32), .EARLY_OUT(1'b0)) dut_full (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start2),
        .flush_i (flush),
        .src1_i  (src1),
        .src2_i  (src2),
        .rd_i    (rd),
        .busy_o  (busy2),
        .stall_o (stall2),
        .valid_o (valid2),
        .data_o  (data2),
        .zero_o  (zero2),
        .rd_o    (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation on dut and count BUSY cycles until valid_o.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, output int n);
        src1  = a;
        src2  = b;
        rd    = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!valid_o && n < BUDGET) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if ({busy_o, valid_o, zero_o, stall_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy_o, valid_o, zero_o, stall_o});
        end
        total++;
        if (data_o !== 32'h0 || rd_o !== 5'd0) begin
            bad++;
            $display("FAIL reset_data: got data=%h rd=%0d want 0/0", data_o, rd_o);
        end
        total++;
        if ({busy2, valid2, zero2} !== 3'b000 || data2 !== 32'h0 || rd2 !== 5'd0) begin
            bad++;
            $display("FAIL reset_full: got busy=%b valid=%b data=%h want all 0", busy2, valid2, data2);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        int stall_bad;
        src1 = 32'd6; src2 = 32'd7; rd = 5'd5; start = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++;
            $display("FAIL basic_stall_start: got %b want 1", stall_o);
        end
        tick();
        start = 1'b0;
        n = 0;
        stall_bad = 0;
        while (!valid_o && n < BUDGET) begin
            if (!stall_o || !busy_o) stall_bad++;
            n++;
            tick();
        end
        total++;
        if (n !== 3 || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency: got n=%0d valid=%b want 3/1", n, valid_o);
        end
        total++;
        if (data_o !== 32'd42 || zero_o !== 1'b0 || rd_o !== 5'd5) begin
            bad++;
            $display("FAIL basic_result: got %0d/%b/%0d want 42/0/5", data_o, zero_o, rd_o);
        end
        total++;
        if (stall_bad !== 0 || stall_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_stall: got busy_gaps=%0d done_stall=%b want 0/0", stall_bad, stall_o);
        end
        tick();
        total++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 32'd42) begin
            bad++;
            $display("FAIL basic_hold: got valid=%b busy=%b data=%0d want 0/0/42", valid_o, busy_o, data_o);
        end
    endtask

    task automatic test_flush();
        int n;
        src1 = 32'd9; src2 = 32'h8000_0000; rd = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got %b want 0", stall_o);
        end
        tick();
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o || busy_o) n++;
            tick();
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL flush_idle: got %0d active cycles want 0", n);
        end
        total++;
        if (data_o !== 32'd42 || zero_o !== 1'b0 || rd_o !== 5'd5) begin
            bad++;
            $display("FAIL flush_keep: got %0d/%b/%0d want 42/0/5", data_o, zero_o, rd_o);
        end
        run_op(32'd2, 32'd3, 5'd7, n);
        total++;
        if (n !== 2 || data_o !== 32'd6 || rd_o !== 5'd7) begin
            bad++;
            $display("FAIL flush_after: got n=%0d data=%0d rd=%0d want 2/6/7", n, data_o, rd_o);
        end
        tick();
    endtask

    task automatic test_signed();
        int n;
        run_op(32'hFFFF_FFFD, 32'd5, 5'd3, n);
        total++;
        if (n !== 3 || data_o !== 32'hFFFF_FFF1 || zero_o !== 1'b0) begin
            bad++;
            $display("FAIL neg_mcand: got n=%0d data=%h want 3/fffffff1", n, data_o);
        end
        tick();
        run_op(32'd3, 32'hFFFF_FFFB, 5'd4, n);
        total++;
        if (n !== 32 || data_o !== 32'hFFFF_FFF1 || rd_o !== 5'd4) begin
            bad++;
            $display("FAIL neg_mplier: got n=%0d data=%h want 32/fffffff1", n, data_o);
        end
        tick();
    endtask

    task automatic test_zero();
        int n;
        run_op(32'h1234_5678, 32'd0, 5'd10, n);
        total++;
        if (n !== 1 || data_o !== 32'd0 || zero_o !== 1'b1) begin
            bad++;
            $display("FAIL zero_mplier: got n=%0d data=%h zero=%b want 1/0/1", n, data_o, zero_o);
        end
        tick();
        run_op(32'h0001_0000, 32'h0001_0000, 5'd11, n);
        total++;
        if (n !== 17 || data_o !== 32'd0 || zero_o !== 1'b1 || rd_o !== 5'd11) begin
            bad++;
            $display("FAIL overflow: got n=%0d data=%h zero=%b want 17/0/1", n, data_o, zero_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(32'd4, 32'd4, 5'd1, n);
        total++;
        if (n !== 3 || data_o !== 32'd16 || rd_o !== 5'd1) begin
            bad++;
            $display("FAIL b2b_first: got n=%0d data=%0d rd=%0d want 3/16/1", n, data_o, rd_o);
        end
        src1 = 32'd5; src2 = 32'd5; rd = 5'd2; start = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_stall: got %b want 1", stall_o);
        end
        tick();
        start = 1'b0;
        total++;
        if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_rebusy: got busy=%b valid=%b want 1/0", busy_o, valid_o);
        end
        n = 0;
        while (!valid_o && n < BUDGET) begin
            n++;
            tick();
        end
        total++;
        if (n !== 3 || data_o !== 32'd25 || rd_o !== 5'd2) begin
            bad++;
            $display("FAIL b2b_second: got n=%0d data=%0d rd=%0d want 3/25/2", n, data_o, rd_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        src1 = 32'd6; src2 = 32'd7; rd = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy_o, valid_o, zero_o, stall_o} !== 4'b0000 || data_o !== 32'd0 || rd_o !== 5'd0) begin
            bad++;
            $display("FAIL reset_async: got busy=%b valid=%b data=%h rd=%0d want all 0", busy_o, valid_o, data_o, rd_o);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b valid=%b want 0/0", busy_o, valid_o);
        end
    endtask

    task automatic test_no_early_out();
        int n;
        src1 = 32'd6; src2 = 32'd7; rd = 5'd6; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!valid2 && n < BUDGET) begin
            n++;
            tick();
        end
        total++;
        if (n !== 32 || data2 !== 32'd42 || zero2 !== 1'b0 || rd2 !== 5'd6) begin
            bad++;
            $display("FAIL full_latency: got n=%0d data=%0d rd=%0d want 32/42/6", n, data2, rd2);
        end
        total++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL full_isolation: got busy=%b valid=%b want 0/0", busy_o, valid_o);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; flush = 1'b0;
        src1 = '0; src2 = '0; rd = '0;
        test_reset();
        test_basic();
        test_flush();
        test_signed();
        test_zero();
        test_back_to_back();
        test_reset_mid_busy();
        test_no_early_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iter_mul.md
# iter_mul

Iterative shift-add multiplier for the EX stage, used for the multiply operation in place of a single-cycle combinational multiply. It takes the same operands the ALU receives from ID/EX and holds the pipeline with `stall_o` while it works. Its result, destination tag and zero flag go to the EX/MEM register through the EX result mux. The product is the low `WIDTH` bits of `src1_i * src2_i`, which is identical for signed and unsigned operands.

## Interface
- `WIDTH`, 32: operand and result width.
- `EARLY_OUT`, 1: when 1, iteration stops once the remaining multiplier is zero; when 0, always `WIDTH` iterations.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: multiply request. Sampled in IDLE or DONE.
- `flush_i` in 1: abort any operation in progress (branch/exception flush).
- `src1_i` in `WIDTH`: multiplicand. Sampled with `start_i`.
- `src2_i` in `WIDTH`: multiplier. Sampled with `start_i`.
- `rd_i` in 5: destination register tag. Sampled with `start_i`.
- `busy_o` out 1: high while in BUSY.
- `stall_o` out 1: combinational pipeline hold request.
- `valid_o` out 1: one-cycle pulse; `data_o`, `zero_o` and `rd_o` are valid in that cycle.
- `data_o` out `WIDTH`: registered product. Holds its value until the next DONE.
- `zero_o` out 1: registered; equals 1 when `data_o` is all zeros.
- `rd_o` out 5: registered tag of the operation being reported.

## Operation
- Internal registers:
  - `mcand` (`WIDTH` bits)
  - `mplier` (`WIDTH` bits)
  - `acc` (`WIDTH` bits)
  - `cnt` (`$clog2(WIDTH)+1` bits)
  - `tag` (5 bits)
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `start_i & !flush_i`: load `mcand=src1_i`, `mplier=src2_i`, `acc=0`, `cnt=0`, `tag=rd_i`, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: one iteration per cycle.
  - If `mplier[0]`, then `acc += mcand` (mod 2^WIDTH).
  - Then `mcand <<= 1`, `mplier >>= 1` (logical), `cnt++`.
  - Go to DONE after the iteration where `cnt` reaches `WIDTH`.
  - If `EARLY_OUT`=1, also go to DONE after the iteration where the shifted `mplier` is zero.
- DONE:
  - `valid_o=1`; `data_o=acc`, `zero_o=(acc==0)`, `rd_o=tag`, all registered on entry.
  - Next state: BUSY (with a fresh load) if `start_i & !flush_i`, otherwise IDLE. This allows back-to-back operations.
- `flush_i` in any state:
  - Next state is IDLE and no `valid_o` pulse is produced.
  - `data_o`, `zero_o` and `rd_o` keep their previous values.
  - `flush_i` has priority over `start_i` in the same cycle.
- `stall_o = (state==BUSY & !flush_i) | ((state==IDLE | state==DONE) & start_i & !flush_i)`.
  - `stall_o` is low in DONE unless a new start is accepted, so the pipeline advances in the cycle the result is presented.
- `start_i` is ignored while in BUSY.
- Arithmetic: all adds wrap mod 2^WIDTH; overflow is discarded and no flag is raised.

## Timing
- Reset (async): state=IDLE, `busy_o=0`, `valid_o=0`, `data_o=0`, `zero_o=0`, `rd_o=0`, all internal registers 0. A reset during BUSY abandons the operation immediately.
- Number of BUSY cycles, N:
  - `EARLY_OUT`=1: N = max(1, position of the highest set bit of `src2_i` + 1). So `src2_i`=0 gives N=1, and a negative `src2_i` gives N=`WIDTH`.
  - `EARLY_OUT`=0: N = `WIDTH`.
- Latency: `start_i` sampled at edge t → BUSY during cycles t+1..t+N → DONE with `valid_o=1` in cycle t+N+1.
- `valid_o` is high for exactly one cycle per accepted, unflushed start.
- Throughput: with `start_i` held in DONE, the next BUSY begins in cycle t+N+2.

## Test plan
- `src1`=6, `src2`=7, `rd`=5 → N=3; `valid_o` 4 cycles after the start edge; `data_o`=42, `zero_o`=0, `rd_o`=5; `stall_o` high in cycles t..t+3 and low in DONE.
- `src1`=0xFFFFFFFD (−3), `src2`=5 → N=3, `data_o`=0xFFFFFFF1. Then `src1`=3, `src2`=0xFFFFFFFB → N=32, `valid_o` at t+33, `data_o`=0xFFFFFFF1.
- `src1`=0x12345678, `src2`=0 → N=1, `data_o`=0, `zero_o`=1. Then `src1`=0x00010000, `src2`=0x00010000 → `data_o`=0 (overflow wraps), `zero_o`=1, N=17.
- Start 9×0x80000000, assert `flush_i` in the 2nd BUSY cycle → IDLE next cycle, no `valid_o`, `data_o` unchanged. A fresh 2×3 afterwards gives 6.
- Back-to-back: 4×4 (`rd`=1), then `start_i` held in DONE with 5×5 (`rd`=2) → two `valid_o` pulses carrying 16/1 and 25/2, no idle cycle between them.
- Assert `rst_i` asynchronously mid-BUSY → all outputs 0 immediately (before the next edge), state IDLE. `EARLY_OUT`=0 build: 6×7 takes N=32 BUSY cycles.
